// File: rtl/game_pkg.sv
// Shared state encoding and card-game constants for the hand accumulator.
// Consumed by hand_accumulator and card_value_decode.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DEAL     = 3'd1,
        ST_ADD      = 3'd2,
        ST_WAIT_CMD = 3'd3,
        ST_HIT_REQ  = 3'd4,
        ST_DONE     = 3'd5
    } hand_state_t;

    // Totals are handled in 6 bits so the carry past 31 is never lost.
    localparam logic [5:0] BLACKJACK_LIMIT = 6'd21;
    localparam logic [5:0] ACE_BONUS       = 6'd10;
    localparam logic [5:0] ACE_HIGH        = 6'd1 + ACE_BONUS;
    localparam logic [2:0] MAX_CARDS       = 3'd5;

    localparam logic [3:0] RANK_ACE    = 4'd1;
    localparam logic [3:0] RANK_TEN    = 4'd10;
    localparam logic [3:0] RANK_JACK   = 4'd11;
    localparam logic [3:0] RANK_QUEEN  = 4'd12;
    localparam logic [3:0] RANK_KING   = 4'd13;
    localparam logic [3:0] FACE_POINTS = 4'd10;

    function automatic logic rank_is_legal(input logic [3:0] rank);
        return (rank >= RANK_ACE) && (rank <= RANK_KING);
    endfunction

endpackage

// File: rtl/card_value_decode.sv
// Combinational rank-to-points decoder: aces report 1 point plus an is_ace
// flag so the accumulator can decide between 1 and 11.
module card_value_decode
    import game_pkg::*;
(
    input  logic [3:0] rank,
    output logic [3:0] points,
    output logic       is_ace,
    output logic       legal
);

    always_comb begin
        points = 4'd0;
        is_ace = 1'b0;
        legal  = rank_is_legal(rank);
        if (legal) begin
            if (rank == RANK_ACE) begin
                is_ace = 1'b1;
                points = 4'd1;
            end else if (rank >= RANK_JACK) begin
                points = FACE_POINTS;
            end else begin
                points = rank;
            end
        end
    end

endmodule

// File: rtl/hand_accumulator.sv
// Blackjack hand accumulator: requests cards, totals them with soft-ace
// handling and reports the finished hand. Define HAND_AUTO_STAND_EN to end
// the hand automatically on a total of 21 after the second or a later card.
module hand_accumulator
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       newGame,
    input  logic       hit,
    input  logic       stand,
    input  logic       cardValid,
    input  logic [3:0] cardValue,
    output logic       cardReq,
    output logic       finish,
    output logic [4:0] totalValue,
    output logic       bust,
    output logic [2:0] cardCount
);

    hand_state_t state;
    logic        soft_ace;
    logic [3:0]  card_pts;
    logic        card_ace;

    logic [3:0]  dec_points;
    logic        dec_is_ace;
    logic        dec_legal;
    logic        card_accept;

    logic        ace_high;
    logic [5:0]  add_pts;
    logic [5:0]  sum_raw;
    logic [5:0]  sum_adj;
    logic        soft_next;
    logic        bust_next;
    logic [2:0]  count_next;

    card_value_decode u_decode (
        .rank   (cardValue),
        .points (dec_points),
        .is_ace (dec_is_ace),
        .legal  (dec_legal)
    );

    assign card_accept = cardReq && cardValid && dec_legal;

    // Arithmetic of the ADD cycle, working on the card latched at acceptance.
    always_comb begin
        ace_high   = ({1'b0, totalValue} + ACE_HIGH) <= BLACKJACK_LIMIT;
        add_pts    = card_ace ? (ace_high ? ACE_HIGH : 6'd1) : {2'b00, card_pts};
        sum_raw    = {1'b0, totalValue} + add_pts;
        soft_next  = soft_ace | (card_ace & ace_high);
        sum_adj    = sum_raw;
        if ((sum_raw > BLACKJACK_LIMIT) && soft_next) begin
            sum_adj   = sum_raw - ACE_BONUS;
            soft_next = 1'b0;
        end
        bust_next  = sum_adj > BLACKJACK_LIMIT;
        count_next = cardCount + 3'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cardReq    <= 1'b0;
            finish     <= 1'b0;
            bust       <= 1'b0;
            totalValue <= 5'd0;
            cardCount  <= 3'd0;
            soft_ace   <= 1'b0;
            card_pts   <= 4'd0;
            card_ace   <= 1'b0;
        end else if (newGame) begin
            // A card offered in this same cycle is deliberately dropped.
            state      <= ST_DEAL;
            cardReq    <= 1'b1;
            finish     <= 1'b0;
            bust       <= 1'b0;
            totalValue <= 5'd0;
            cardCount  <= 3'd0;
            soft_ace   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cardReq <= 1'b0;
                end
                ST_DEAL, ST_HIT_REQ: begin
                    if (card_accept) begin
                        card_pts <= dec_points;
                        card_ace <= dec_is_ace;
                        cardReq  <= 1'b0;
                        state    <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    totalValue <= sum_adj[4:0];
                    soft_ace   <= soft_next;
                    cardCount  <= count_next;
                    if (bust_next) begin
                        bust   <= 1'b1;
                        finish <= 1'b1;
                        state  <= ST_DONE;
                    end else if (count_next < 3'd2) begin
                        cardReq <= 1'b1;
                        state   <= ST_DEAL;
                    end else if (count_next == MAX_CARDS) begin
                        finish <= 1'b1;
                        state  <= ST_DONE;
`ifdef HAND_AUTO_STAND_EN
                    end else if (sum_adj == BLACKJACK_LIMIT) begin
                        finish <= 1'b1;
                        state  <= ST_DONE;
`endif
                    end else begin
                        state <= ST_WAIT_CMD;
                    end
                end
                ST_WAIT_CMD: begin
                    if (stand) begin
                        finish <= 1'b1;
                        state  <= ST_DONE;
                    end else if (hit) begin
                        cardReq <= 1'b1;
                        state   <= ST_HIT_REQ;
                    end
                end
                ST_DONE: begin
                    finish <= 1'b1;
                end
                default: begin
                    cardReq <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hand_accumulator.sv
// Directed self-checking bench for hand_accumulator; expected totals are
// worked out by hand for each hand dealt.
module tb_hand_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       newGame;
    logic       hit;
    logic       stand;
    logic       cardValid;
    logic [3:0] cardValue;
    logic       cardReq;
    logic       finish;
    logic [4:0] totalValue;
    logic       bust;
    logic [2:0] cardCount;

    int n_cmp = 0;
    int n_err = 0;

    hand_accumulator dut (
        .clk        (clk),
        .rst        (rst),
        .newGame    (newGame),
        .hit        (hit),
        .stand      (stand),
        .cardValid  (cardValid),
        .cardValue  (cardValue),
        .cardReq    (cardReq),
        .finish     (finish),
        .totalValue (totalValue),
        .bust       (bust),
        .cardCount  (cardCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_game();
        newGame = 1'b1;
        tick();
        newGame = 1'b0;
    endtask

    task automatic give_card(input logic [3:0] v);
        int waited = 0;
        while (!cardReq && waited < 10) begin
            tick();
            waited++;
        end
        if (!cardReq) begin
            check("card_req_timeout", 32'(cardReq), 32'd1);
        end else begin
            cardValid = 1'b1;
            cardValue = v;
            tick();
            cardValid = 1'b0;
            cardValue = 4'd0;
            tick();
        end
    endtask

    task automatic do_hit();
        hit = 1'b1;
        tick();
        hit = 1'b0;
    endtask

    task automatic do_stand();
        stand = 1'b1;
        tick();
        stand = 1'b0;
    endtask

    task automatic check_hand(input string tag, input logic [4:0] tot, input logic [2:0] cnt,
                              input logic bst, input logic fin);
        check({tag, "_total"}, 32'(totalValue), 32'(tot));
        check({tag, "_count"}, 32'(cardCount), 32'(cnt));
        check({tag, "_bust"}, 32'(bust), 32'(bst));
        check({tag, "_finish"}, 32'(finish), 32'(fin));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; newGame = 1'b0; hit = 1'b0; stand = 1'b0;
        cardValid = 1'b0; cardValue = 4'd0;
        tick(); tick();
        rst = 1'b0;
        check_hand("reset", 5'd0, 3'd0, 1'b0, 1'b0);
        check("reset_req", 32'(cardReq), 32'd0);
        // Idle with stray hit/stand and a valid card: nothing may move.
        hit = 1'b1; stand = 1'b1; cardValid = 1'b1; cardValue = 4'd5;
        tick(); tick();
        hit = 1'b0; stand = 1'b0; cardValid = 1'b0;
        check_hand("idle", 5'd0, 3'd0, 1'b0, 1'b0);
        check("idle_req", 32'(cardReq), 32'd0);

        // 10 + K, stand -> 20
        new_game();
        check("deal_req", 32'(cardReq), 32'd1);
        give_card(4'd10);
        check_hand("h1_c1", 5'd10, 3'd1, 1'b0, 1'b0);
        give_card(4'd13);
        check_hand("h1_c2", 5'd20, 3'd2, 1'b0, 1'b0);
        do_stand();
        check_hand("h1_done", 5'd20, 3'd2, 1'b0, 1'b1);
        tick(); tick(); tick();
        check_hand("h1_hold", 5'd20, 3'd2, 1'b0, 1'b1);

        // A + 6 soft 17, hit 9 -> ace demoted, 16
        new_game();
        check_hand("h2_clear", 5'd0, 3'd0, 1'b0, 1'b0);
        give_card(4'd1);
        check("h2_c1_total", 32'(totalValue), 32'd11);
        give_card(4'd6);
        check_hand("h2_c2", 5'd17, 3'd2, 1'b0, 1'b0);
        do_hit();
        check("h2_hitreq", 32'(cardReq), 32'd1);
        give_card(4'd9);
        check_hand("h2_c3", 5'd16, 3'd3, 1'b0, 1'b0);
        check("h2_wait_req", 32'(cardReq), 32'd0);
        do_stand();
        check("h2_finish", 32'(finish), 32'd1);

        // 10 + 5, hit Q -> 25 bust, later hit ignored
        new_game();
        give_card(4'd10);
        give_card(4'd5);
        check("h3_c2_total", 32'(totalValue), 32'd15);
        do_hit();
        give_card(4'd12);
        check_hand("h3_bust", 5'd25, 3'd3, 1'b1, 1'b1);
        do_hit();
        tick();
        check_hand("h3_after_hit", 5'd25, 3'd3, 1'b1, 1'b1);
        check("h3_after_hit_req", 32'(cardReq), 32'd0);

        // 2,2,2,2,3 -> five-card forced stop at 11
        new_game();
        check_hand("h4_clear", 5'd0, 3'd0, 1'b0, 1'b0);
        give_card(4'd2);
        give_card(4'd2);
        do_hit(); give_card(4'd2);
        do_hit(); give_card(4'd2);
        check_hand("h4_c4", 5'd8, 3'd4, 1'b0, 1'b0);
        do_hit(); give_card(4'd3);
        check_hand("h4_c5", 5'd11, 3'd5, 1'b0, 1'b1);
        check("h4_req", 32'(cardReq), 32'd0);

        // Illegal ranks held valid are never accepted; a 7 then is
        new_game();
        cardValid = 1'b1;
        cardValue = 4'd14; tick();
        cardValue = 4'd0;  tick();
        cardValue = 4'd15; tick();
        check("bad_req", 32'(cardReq), 32'd1);
        check("bad_count", 32'(cardCount), 32'd0);
        check("bad_total", 32'(totalValue), 32'd0);
        cardValue = 4'd7; tick();
        cardValid = 1'b0;
        check("good_in_add_req", 32'(cardReq), 32'd0);
        tick();
        check_hand("good_c1", 5'd7, 3'd1, 1'b0, 1'b0);
        check("good_deal_req", 32'(cardReq), 32'd1);

        // Reset while in HIT_REQ abandons the hand
        new_game();
        give_card(4'd10);
        give_card(4'd3);
        do_hit();
        check("rst_in_hitreq", 32'(cardReq), 32'd1);
        rst = 1'b1; newGame = 1'b1;
        tick();
        rst = 1'b0; newGame = 1'b0;
        check_hand("rst_mid", 5'd0, 3'd0, 1'b0, 1'b0);
        check("rst_mid_req", 32'(cardReq), 32'd0);
        tick(); tick();
        check("rst_no_finish", 32'(finish), 32'd0);

        // hit and stand together in WAIT_CMD -> stand wins
        new_game();
        give_card(4'd4);
        give_card(4'd5);
        hit = 1'b1; stand = 1'b1;
        tick();
        hit = 1'b0; stand = 1'b0;
        check_hand("both_cmd", 5'd9, 3'd2, 1'b0, 1'b1);
        check("both_cmd_req", 32'(cardReq), 32'd0);

        // newGame coincident with a card: the card is dropped
        new_game();
        newGame = 1'b1; cardValid = 1'b1; cardValue = 4'd5;
        tick();
        newGame = 1'b0; cardValid = 1'b0;
        tick();
        check("ng_drop_count", 32'(cardCount), 32'd0);
        check("ng_drop_req", 32'(cardReq), 32'd1);

        // A, A -> 12; hit 10 -> soft ace absorbs, 12
        give_card(4'd1);
        give_card(4'd1);
        check_hand("aa_c2", 5'd12, 3'd2, 1'b0, 1'b0);
        do_hit();
        give_card(4'd10);
        check_hand("aa_c3", 5'd12, 3'd3, 1'b0, 1'b0);

        // 10 + A = 21 on two cards
        new_game();
        give_card(4'd10);
        give_card(4'd1);
`ifdef HAND_AUTO_STAND_EN
        check_hand("bj21", 5'd21, 3'd2, 1'b0, 1'b1);
`else
        check_hand("bj21", 5'd21, 3'd2, 1'b0, 1'b0);
        do_stand();
        check("bj21_stand", 32'(finish), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
